// File: rtl/time_counter.sv
// Time-of-day counter: hh:mm:ss advanced by rising edges of a 1 Hz tick, loadable via set_valid/set_ready.
// Latency: a counted tick or an accepted load is visible on hour/min/sec one cycle later.
// Backpressure: set_ready drops for the single LOAD cycle after an accepted load; requests then are ignored.
// Optional alarm comparator enabled by defining TIME_COUNTER_ALARM_EN.
module time_counter #(
  parameter int HOURS_PER_DAY = 24
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       set_valid,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic       set_ready,
  output logic       set_err,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_pulse,
  output logic       day_wrap
`ifdef TIME_COUNTER_ALARM_EN
  ,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_on,
  output logic       alarm_hit
`endif
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [0:0] r_state;
  logic       r_tick_d;
  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic       r_sec_pulse;
  logic       r_day_wrap;
  logic       r_set_err;

  logic       w_edge;
  logic       w_accept;
  logic       w_set_ok;
  logic       w_count;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic       w_hour_wrap;
  logic [4:0] w_hour_nxt;
  logic [5:0] w_min_nxt;
  logic [5:0] w_sec_nxt;

  assign w_edge    = tick_in & ~r_tick_d;
  assign set_ready = (r_state == ST_RUN);
  assign w_accept  = set_valid & set_ready;
  // Hour compared at 6 bits so HOURS_PER_DAY=32 is representable.
  assign w_set_ok  = ({1'b0, set_hour} < 6'(HOURS_PER_DAY)) && (set_min < 6'd60) && (set_sec < 6'd60);
  // A load wins over a coincident edge; edges during LOAD are dropped.
  assign w_count   = w_edge & (r_state == ST_RUN) & ~w_accept;

  assign w_sec_wrap  = (r_sec == 6'd59);
  assign w_min_wrap  = (r_min == 6'd59);
  assign w_hour_wrap = (r_hour == 5'(HOURS_PER_DAY - 1));

  // Next time value after one second, with the sec->min->hour carry chain.
  always_comb begin
    w_sec_nxt  = r_sec + 6'd1;
    w_min_nxt  = r_min;
    w_hour_nxt = r_hour;
    if (w_sec_wrap) begin
      w_sec_nxt = 6'd0;
      if (w_min_wrap) begin
        w_min_nxt  = 6'd0;
        w_hour_nxt = w_hour_wrap ? 5'd0 : r_hour + 5'd1;
      end else begin
        w_min_nxt = r_min + 6'd1;
      end
    end
  end

  // State, tick history, time registers and status pulses.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_tick_d    <= 1'b0;
      r_hour      <= 5'd0;
      r_min       <= 6'd0;
      r_sec       <= 6'd0;
      r_sec_pulse <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      r_tick_d    <= tick_in;
      r_sec_pulse <= w_count;
      r_day_wrap  <= w_count & w_sec_wrap & w_min_wrap & w_hour_wrap;
      r_set_err   <= w_accept & ~w_set_ok;
      r_state     <= w_accept ? ST_LOAD : ST_RUN;
      if (w_accept) begin
        if (w_set_ok) begin
          r_hour <= set_hour;
          r_min  <= set_min;
          r_sec  <= set_sec;
        end
      end else if (w_count) begin
        r_hour <= w_hour_nxt;
        r_min  <= w_min_nxt;
        r_sec  <= w_sec_nxt;
      end
    end
  end

  assign hour      = r_hour;
  assign min       = r_min;
  assign sec       = r_sec;
  assign sec_pulse = r_sec_pulse;
  assign day_wrap  = r_day_wrap;
  assign set_err   = r_set_err;

`ifdef TIME_COUNTER_ALARM_EN
  logic r_alarm_hit;

  // Alarm fires only on a tick advance landing exactly on alarm_hour:alarm_min:00.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_alarm_hit <= 1'b0;
    end else begin
      r_alarm_hit <= w_count & alarm_on & (w_sec_nxt == 6'd0) &
                     (w_min_nxt == alarm_min) & (w_hour_nxt == alarm_hour);
    end
  end

  assign alarm_hit = r_alarm_hit;
`endif

endmodule
